// File: rtl/park_pkg.sv
// Shared types and sensor phase patterns for the parking-lot sensor emulator.
// Patterns are {SIG_A, SIG_B}.
package park_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4,
        GAP  = 3'd5
    } emu_state_t;

    localparam logic [1:0] ENT_PH1 = 2'b10;
    localparam logic [1:0] ENT_PH2 = 2'b11;
    localparam logic [1:0] ENT_PH3 = 2'b01;
    localparam logic [1:0] EXT_PH1 = 2'b01;
    localparam logic [1:0] EXT_PH2 = 2'b11;
    localparam logic [1:0] EXT_PH3 = 2'b10;
    localparam logic [1:0] AB_IDLE = 2'b00;

    function automatic logic [1:0] phase_pattern(input emu_state_t st, input logic dir);
        logic [1:0] ab;
        case (st)
            PH1:     ab = dir ? ENT_PH1 : EXT_PH1;
            PH2:     ab = dir ? ENT_PH2 : EXT_PH2;
            PH3:     ab = dir ? ENT_PH3 : EXT_PH3;
            default: ab = AB_IDLE;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    // Count down from the loaded value and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/car_sensor_emulator.sv
// Emits one legal enter/exit SIG_A/SIG_B sequence per accepted request, then
// a quiet gap, a DONE pulse and a per-direction event count.
module car_sensor_emulator
    import park_pkg::*;
#(
    parameter int PHASE_CYCLES = 5_000_000,
    parameter int GAP_CYCLES   = 5_000_000,
    parameter int CNT_W        = 8
) (
    input  logic             CLOCK_50,
    input  logic             RSTN,
    input  logic             REQ_ENTER,
    input  logic             REQ_EXIT,
    output logic             READY,
    output logic             SIG_A,
    output logic             SIG_B,
    output logic             DONE,
    output logic             DIR,
    output logic [CNT_W-1:0] ENTER_CNT,
    output logic [CNT_W-1:0] EXIT_CNT
);

    localparam int MAX_CYCLES = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] PHASE_LOAD = TW'(PHASE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    emu_state_t       state_r;
    logic             ready_r, sig_a_r, sig_b_r, done_r, dir_r;
    logic [CNT_W-1:0] enter_cnt_r, exit_cnt_r;
    logic             tc_s, load_s;
    logic [TW-1:0]    load_val_s;

    phase_timer #(.W(TW)) u_timer (
        .clk      (CLOCK_50),
        .rst_n    (RSTN),
        .load     (load_s),
        .load_val (load_val_s),
        .tc       (tc_s)
    );

    // Reload the timer on the same edge the FSM enters a timed state.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = PHASE_LOAD;
        if (state_r == IDLE) begin
            load_s = REQ_ENTER | REQ_EXIT;
        end else if ((state_r == PH1) || (state_r == PH2)) begin
            load_s = tc_s;
        end else if (state_r == PH4) begin
            load_s     = 1'b1;
            load_val_s = GAP_LOAD;
        end else begin
            load_s = 1'b0;
        end
    end

    // Sequencing FSM with registered sensor, handshake and counter outputs.
    always_ff @(posedge CLOCK_50 or negedge RSTN) begin
        if (!RSTN) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            sig_a_r     <= 1'b0;
            sig_b_r     <= 1'b0;
            done_r      <= 1'b0;
            dir_r       <= 1'b0;
            enter_cnt_r <= {CNT_W{1'b0}};
            exit_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (REQ_ENTER) begin
                        dir_r                <= 1'b1;
                        state_r              <= PH1;
                        ready_r              <= 1'b0;
                        {sig_a_r, sig_b_r}   <= ENT_PH1;
                    end else if (REQ_EXIT) begin
                        dir_r                <= 1'b0;
                        state_r              <= PH1;
                        ready_r              <= 1'b0;
                        {sig_a_r, sig_b_r}   <= EXT_PH1;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                PH1: begin
                    if (tc_s) begin
                        state_r            <= PH2;
                        {sig_a_r, sig_b_r} <= phase_pattern(PH2, dir_r);
                    end
                end
                PH2: begin
                    if (tc_s) begin
                        state_r            <= PH3;
                        {sig_a_r, sig_b_r} <= phase_pattern(PH3, dir_r);
                    end
                end
                PH3: begin
                    if (tc_s) begin
                        state_r            <= PH4;
                        {sig_a_r, sig_b_r} <= AB_IDLE;
                    end
                end
                PH4: begin
                    state_r <= GAP;
                end
                GAP: begin
                    if (tc_s) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        done_r  <= 1'b1;
                        if (dir_r) begin
                            enter_cnt_r <= enter_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            exit_cnt_r  <= exit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_r            <= IDLE;
                    ready_r            <= 1'b1;
                    {sig_a_r, sig_b_r} <= AB_IDLE;
                end
            endcase
        end
    end

    assign READY     = ready_r;
    assign SIG_A     = sig_a_r;
    assign SIG_B     = sig_b_r;
    assign DONE      = done_r;
    assign DIR       = dir_r;
    assign ENTER_CNT = enter_cnt_r;
    assign EXIT_CNT  = exit_cnt_r;

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Directed bench for car_sensor_emulator with PHASE_CYCLES=4, GAP_CYCLES=3.
module tb_car_sensor_emulator;

    logic       clk;
    logic       rstn;
    logic       req_enter;
    logic       req_exit;
    logic       ready, sig_a, sig_b, done, dir;
    logic [7:0] enter_cnt, exit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    car_sensor_emulator #(
        .PHASE_CYCLES (4),
        .GAP_CYCLES   (3),
        .CNT_W        (8)
    ) dut (
        .CLOCK_50  (clk),
        .RSTN      (rstn),
        .REQ_ENTER (req_enter),
        .REQ_EXIT  (req_exit),
        .READY     (ready),
        .SIG_A     (sig_a),
        .SIG_B     (sig_b),
        .DONE      (done),
        .DIR       (dir),
        .ENTER_CNT (enter_cnt),
        .EXIT_CNT  (exit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_ab(input logic enter, input int i);
        if (i < 4)       return enter ? 2'b10 : 2'b01;
        else if (i < 8)  return 2'b11;
        else if (i < 12) return enter ? 2'b01 : 2'b10;
        else             return 2'b00;
    endfunction

    // Present a one-cycle request; returns at the first sample after acceptance.
    task automatic request(input logic ent, input logic ext);
        req_enter = ent;
        req_exit  = ext;
        tick();
        req_enter = 1'b0;
        req_exit  = 1'b0;
    endtask

    // Walk samples 0..16 after acceptance; DONE must land on sample 16.
    task automatic follow_seq(input logic enter, input logic mid_exit);
        logic [1:0] prev_ab;
        prev_ab = 2'b00;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) check("ab", {30'd0, sig_a, sig_b}, {30'd0, exp_ab(enter, i)});
            check("done", {31'd0, done}, {31'd0, (i == 16)});
            check("single_toggle", {31'd0, ($countones(prev_ab ^ {sig_a, sig_b}) <= 1)}, 32'd1);
            if (i == 0)  check("dir", {31'd0, dir}, {31'd0, enter});
            if (i == 1)  check("ready_low", {31'd0, ready}, 32'd0);
            if (i == 16) check("ready_back", {31'd0, ready}, 32'd1);
            prev_ab = {sig_a, sig_b};
            req_exit = (mid_exit && i == 5);
            if (i < 16) tick();
        end
        req_exit = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        int dones;
        int budget;
        req_enter = 1'b0;
        req_exit  = 1'b0;
        rstn      = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // 1: reset state and quiet idle
        check("rst_ab",    {30'd0, sig_a, sig_b}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_dir",   {31'd0, dir}, 32'd0);
        check("rst_ecnt",  {24'd0, enter_cnt}, 32'd0);
        check("rst_xcnt",  {24'd0, exit_cnt}, 32'd0);

        // 2: single enter
        request(1'b1, 1'b0);
        follow_seq(1'b1, 1'b0);
        check("enter_cnt1", {24'd0, enter_cnt}, 32'd1);
        check("exit_cnt0",  {24'd0, exit_cnt}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("dir_hold", {31'd0, dir}, 32'd1);

        // 3: single exit
        request(1'b0, 1'b1);
        follow_seq(1'b0, 1'b0);
        check("exit_cnt1", {24'd0, exit_cnt}, 32'd1);
        check("enter_keep", {24'd0, enter_cnt}, 32'd1);
        tick();
        check("dir_hold_exit", {31'd0, dir}, 32'd0);

        // 4: simultaneous requests, exit pulsed mid-sequence
        request(1'b1, 1'b1);
        follow_seq(1'b1, 1'b1);
        check("both_enter_cnt", {24'd0, enter_cnt}, 32'd2);
        check("both_exit_cnt",  {24'd0, exit_cnt}, 32'd1);
        tick();
        tick();
        check("no_requeue_ready", {31'd0, ready}, 32'd1);
        check("no_requeue_ab", {30'd0, sig_a, sig_b}, 32'd0);

        // 5: reset during PH2
        request(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_ab", {30'd0, sig_a, sig_b}, 32'd3);
        rstn = 1'b0;
        #1;
        check("async_ab",    {30'd0, sig_a, sig_b}, 32'd0);
        check("async_ready", {31'd0, ready}, 32'd1);
        check("async_ecnt",  {24'd0, enter_cnt}, 32'd0);
        check("async_xcnt",  {24'd0, exit_cnt}, 32'd0);
        check("async_dir",   {31'd0, dir}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        request(1'b1, 1'b0);
        follow_seq(1'b1, 1'b0);
        check("post_rst_ecnt", {24'd0, enter_cnt}, 32'd1);

        // 6: held request, 300 back-to-back sequences
        do_reset();
        tick();
        req_enter = 1'b1;
        dones  = 0;
        budget = 300 * 17 + 200;
        while (dones < 300 && budget > 0) begin
            tick();
            budget--;
            if (done) begin
                dones++;
                if (dones == 1)   check("b2b_cnt1", {24'd0, enter_cnt}, 32'd1);
                if (dones == 255) check("cnt_255", {24'd0, enter_cnt}, 32'd255);
                if (dones == 256) check("cnt_wrap", {24'd0, enter_cnt}, 32'd0);
                if (dones == 1) begin
                    tick();
                    budget--;
                    check("b2b_retrigger", {31'd0, ready}, 32'd0);
                end
            end
        end
        req_enter = 1'b0;
        check("b2b_all_done", dones, 32'd300);
        check("cnt_300", {24'd0, enter_cnt}, 32'd44);
        check("b2b_exit_cnt", {24'd0, exit_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/car_sensor_emulator.md
Name: car_sensor_emulator

Overview:
- Generates the two-sensor gate waveforms (SIG_A, SIG_B) that the parking-lot entry/exit detector consumes. It is the transmitting end of the sensor protocol.
- One request produces one complete, legal car-enter or car-exit sequence with programmable phase timing.
- Used as an on-board demo source or a BIST driver in place of the GPIO switches. Its outputs are muxed onto the detector's SIG_A/SIG_B inputs at top level.

Parameters:
- PHASE_CYCLES, 5_000_000: clock cycles each sensor phase is held (100 ms at 50 MHz). Must be ≥1.
- GAP_CYCLES, 5_000_000: idle cycles with both sensors low after the final phase, before READY reasserts. Must be ≥1.
- CNT_W, 8: width of the generated-event counters.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- RSTN  input  1  asynchronous active-low reset
- REQ_ENTER  input  1  request one enter sequence; sampled only while READY=1
- REQ_EXIT  input  1  request one exit sequence; sampled only while READY=1
- READY  output  1  high when idle and able to accept a request
- SIG_A  output  1  emulated outer sensor A, registered
- SIG_B  output  1  emulated inner sensor B, registered
- DONE  output  1  one-cycle pulse when a sequence, including its gap, completes
- DIR  output  1  direction of the current or last sequence: 1=enter, 0=exit
- ENTER_CNT  output  CNT_W  number of completed enter sequences, wraps modulo 2^CNT_W
- EXIT_CNT  output  CNT_W  number of completed exit sequences, wraps modulo 2^CNT_W

Behaviour:
- Reset (RSTN=0, asynchronous, any time including mid-sequence):
  - State→IDLE, phase counter→0.
  - SIG_A=0, SIG_B=0, READY=1, DONE=0, DIR=0, ENTER_CNT=0, EXIT_CNT=0.
  - The interrupted sequence is abandoned and not counted.
- FSM states: IDLE, PH1, PH2, PH3, PH4, GAP.
- IDLE:
  - READY=1, SIG_A=SIG_B=0.
  - On a rising clock edge with REQ_ENTER=1: DIR←1, go to PH1.
  - Else with REQ_EXIT=1: DIR←0, go to PH1.
  - REQ_ENTER and REQ_EXIT both high: enter wins; the exit request is dropped, not queued.
- Request acceptance:
  - READY deasserts in the cycle after acceptance.
  - Requests while READY=0 are ignored.
  - Requests are level-sampled: a REQ held high re-triggers a new sequence the first cycle READY is 1 again.
- Phase outputs, registered and changing on the cycle the state is entered:
  - Enter (DIR=1): PH1 A=1,B=0; PH2 A=1,B=1; PH3 A=0,B=1; PH4 A=0,B=0.
  - Exit (DIR=0): PH1 A=0,B=1; PH2 A=1,B=1; PH3 A=1,B=0; PH4 A=0,B=0.
- Timing:
  - PH1–PH3 each last exactly PHASE_CYCLES cycles.
  - PH4 lasts 1 cycle, then the FSM moves to GAP.
  - GAP lasts GAP_CYCLES cycles with A=B=0.
  - On GAP exit: DONE=1 for exactly 1 cycle, the matching counter (ENTER_CNT if DIR=1, else EXIT_CNT) increments in the same cycle, and state→IDLE with READY=1 in that same cycle.
- Only one sensor output changes per phase transition; SIG_A and SIG_B never toggle in the same cycle.
- Phase counter: width $clog2(max(PHASE_CYCLES, GAP_CYCLES)+1). Cleared on every state change; counts 0..N-1.
- Total latency from acceptance edge to DONE pulse: 3·PHASE_CYCLES + 1 + GAP_CYCLES cycles.
- DIR holds its value after DONE until the next acceptance.
- Counter wrap: 2^CNT_W-1 → 0, with no saturation.

Decomposition:
- Shared package park_pkg:
  - state enum emu_state_t {IDLE, PH1, PH2, PH3, PH4, GAP}
  - localparams for the phase output patterns (2-bit {A,B} per phase, per direction)
- Sub-module phase_timer:
  - Loadable down-counter with a terminal-count flag.
  - Instanced once and reused for both phase and gap durations.
- Top FSM, output registers and event counters live in car_sensor_emulator.

Test Plan:
All scenarios use PHASE_CYCLES=4, GAP_CYCLES=3, CNT_W=8.
1. Reset held, then released → SIG_A=SIG_B=0, READY=1, both counters=0; no change without requests.
2. Single REQ_ENTER pulse → {A,B}: 10×4, 11×4, 01×4, 00×1, gap 00×3; DONE pulse at cycle 16 after acceptance; ENTER_CNT=1, DIR=1.
3. Single REQ_EXIT pulse → {A,B}: 01, 11, 10 (×4 each), then 00; EXIT_CNT=1, DIR=0. Loopback through the detector produces exactly one EXIT pulse.
4. REQ_ENTER and REQ_EXIT asserted together → an enter sequence only; ENTER_CNT=1, EXIT_CNT=0. A REQ_EXIT pulsed mid-sequence is ignored.
5. RSTN dropped during PH2 → outputs go to 00 asynchronously, READY=1, counters 0. The next REQ_ENTER runs a full sequence from PH1.
6. REQ_ENTER held high for 300 sequences → back-to-back sequences; ENTER_CNT wraps 255→0 and reads 44 after 300 DONE pulses.
